wb_trace_sink: RTL and testbench

Receiving end of the core's writeback trace port (write-enable/address/data plus program counter). It captures every architectural register write into a FIFO and keeps a shadow copy of the 32-entry register file. Records drain over a valid/ready stream toward the bench or a debug link. On request it streams a full register-file dump, so retirement can be checked without probing the decode stage.

---
 rtl/wb_trace_sink_pkg.sv | 19 +
 rtl/wb_trace_fifo.sv | 47 ++++
 rtl/wb_trace_sink.sv | 116 +++++++++++
 tb/tb_wb_trace_sink.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/wb_trace_sink_pkg.sv
// rtl/wb_trace_sink_pkg.sv - shared record and state types for the writeback trace sink
package wb_trace_sink_pkg;

  localparam int NUM_REGS = 32;

  typedef struct packed {
    logic        is_dump;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] pc;
  } wb_rec_s;

  typedef enum logic [1:0] {
    WTS_IDLE,
    WTS_WAIT_DRAIN,
    WTS_DUMP
  } wts_state_e;

endpackage

// File: rtl/wb_trace_fifo.sv
// rtl/wb_trace_fifo.sv - synchronous FIFO of trace records
// A push into a full FIFO is honoured when a pop happens in the same cycle.
module wb_trace_fifo
  import wb_trace_sink_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  logic    pop,
  input  wb_rec_s din,
  output logic    full,
  output logic    empty,
  output wb_rec_s head
);

  localparam int AW = $clog2(DEPTH);

  wb_rec_s       mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/wb_trace_sink.sv
// rtl/wb_trace_sink.sv - writeback trace capture with shadow register file and dump stream
module wb_trace_sink
  import wb_trace_sink_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wb_e,
  input  logic [4:0]       wb_a,
  input  logic [31:0]      wb_d,
  input  logic [31:0]      trace_pc,
  input  logic             dump_req,
  output logic             out_valid,
  input  logic             out_ready,
  output wb_rec_s          out_rec,
  output logic             busy,
  output logic             overflow,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] drop_cnt
);

  wts_state_e  state, state_next;
  logic [4:0]  idx, idx_next;
  logic [31:0] shadow [NUM_REGS];

  logic    wb_hit;
  logic    accept;
  logic    drop;
  logic    fifo_pop;
  logic    fifo_full;
  logic    fifo_empty;
  wb_rec_s fifo_head;
  wb_rec_s fifo_din;

  assign wb_hit   = wb_e && (wb_a != 5'd0);
  assign fifo_pop = out_valid && out_ready && (state != WTS_DUMP);
  assign accept   = wb_hit && (!fifo_full || fifo_pop);
  assign drop     = wb_hit && fifo_full && !fifo_pop;
  assign fifo_din = '{is_dump: 1'b0, addr: wb_a, data: wb_d, pc: trace_pc};

  wb_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  // Shadow tracks architectural state even when the trace record is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
    end else if (wb_hit) begin
      shadow[wb_a] <= wb_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      retire_cnt <= '0;
      drop_cnt   <= '0;
      overflow   <= 1'b0;
    end else begin
      if (accept) retire_cnt <= retire_cnt + CNT_W'(1);
      if (drop) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
        overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= WTS_IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx;
    out_valid  = !fifo_empty;
    out_rec    = fifo_empty ? '0 : fifo_head;
    busy       = (state != WTS_IDLE);
    case (state)
      WTS_IDLE: begin
        if (dump_req) state_next = WTS_WAIT_DRAIN;
      end
      WTS_WAIT_DRAIN: begin
        if (fifo_empty) begin
          state_next = WTS_DUMP;
          idx_next   = '0;
        end
      end
      WTS_DUMP: begin
        // Data is read live so a write landing during a stall is reflected.
        out_valid = 1'b1;
        out_rec   = '{is_dump: 1'b1, addr: idx, data: shadow[idx], pc: '0};
        if (out_ready) begin
          idx_next = idx + 5'd1;
          if (idx == 5'd31) state_next = WTS_IDLE;
        end
      end
      default: state_next = WTS_IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_trace_sink.sv
// tb/tb_wb_trace_sink.sv - randomized bench for wb_trace_sink against a queue-based model
module tb_wb_trace_sink;
  import wb_trace_sink_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             wb_e;
  logic [4:0]       wb_a;
  logic [31:0]      wb_d;
  logic [31:0]      trace_pc;
  logic             dump_req;
  logic             out_valid;
  logic             out_ready;
  wb_rec_s          out_rec;
  logic             busy;
  logic             overflow;
  logic [CNT_W-1:0] retire_cnt;
  logic [CNT_W-1:0] drop_cnt;

  wb_trace_sink #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .wb_e       (wb_e),
    .wb_a       (wb_a),
    .wb_d       (wb_d),
    .trace_pc   (trace_pc),
    .dump_req   (dump_req),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_rec    (out_rec),
    .busy       (busy),
    .overflow   (overflow),
    .retire_cnt (retire_cnt),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: mode 0 = normal, 1 = waiting for drain, 2 = dumping.
  wb_rec_s     mq[$];
  logic [31:0] msh [32];
  int          mode;
  int          didx;
  logic [31:0] mret;
  logic [31:0] mdrop;
  bit          movf;

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < 32; i++) msh[i] = '0;
    mode  = 0;
    didx  = 0;
    mret  = '0;
    mdrop = '0;
    movf  = 1'b0;
  endtask

  // Called at a falling edge: check current outputs, apply inputs, advance model one edge.
  task automatic cycle(input bit r, input bit e, input logic [4:0] a, input logic [31:0] d,
                       input logic [31:0] pc, input bit req, input bit rdy);
    bit      exp_valid;
    wb_rec_s exp_rec;
    bit      hs;
    bit      was_empty;
    if (mode == 2) begin
      exp_valid = 1'b1;
      exp_rec   = '{1'b1, 5'(didx), msh[didx], 32'd0};
    end else begin
      exp_valid = (mq.size() > 0);
      exp_rec   = exp_valid ? mq[0] : '0;
    end
    check("out_valid", 70'(out_valid), 70'(exp_valid));
    if (exp_valid || mode == 0) check("out_rec", out_rec, exp_rec);
    check("busy", 70'(busy), 70'(mode != 0));
    check("overflow", 70'(overflow), 70'(movf));
    check("retire_cnt", 70'(retire_cnt), 70'(mret));
    check("drop_cnt", 70'(drop_cnt), 70'(mdrop));

    reset = r; wb_e = e; wb_a = a; wb_d = d; trace_pc = pc; dump_req = req; out_ready = rdy;

    if (r) begin
      model_reset();
    end else begin
      hs        = exp_valid && rdy;
      was_empty = (mq.size() == 0);
      if (hs && mode != 2) void'(mq.pop_front());
      if (e && a != 0) begin
        if (mq.size() < DEPTH) begin
          mq.push_back('{1'b0, a, d, pc});
          mret++;
        end else begin
          mdrop++;
          movf = 1'b1;
        end
        msh[a] = d;
      end
      case (mode)
        0: if (req) mode = 1;
        1: if (was_empty) begin mode = 2; didx = 0; end
        default: if (hs) begin
          if (didx == 31) mode = 0;
          didx = (didx + 1) % 32;
        end
      endcase
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit rdy);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, rdy);
  endtask

  task automatic run_to_idle();
    for (int k = 0; k < 300 && mode != 0; k++) idle(1'b1);
    check("dump_done", 70'(mode), 70'd0);
  endtask

  initial begin
    reset = 1'b1; wb_e = 1'b0; wb_a = '0; wb_d = '0; trace_pc = '0; dump_req = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    model_reset();

    // Two consecutive writes streamed with ready held high.
    cycle(1'b0, 1'b1, 5'd5, 32'h11, 32'h1000, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 5'd6, 32'h22, 32'h1004, 1'b0, 1'b1);
    check("retire_two", 70'(retire_cnt), 70'd2);
    cycle(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 32'h1008, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) idle(1'b1);
    check("retire_x0_ignored", 70'(retire_cnt), 70'd2);

    // Overflow: DEPTH+2 events with consumer stalled.
    for (int i = 1; i <= DEPTH + 2; i++)
      cycle(1'b0, 1'b1, 5'(i), $urandom, 32'h2000 + 32'(4*i), 1'b0, 1'b0);
    check("drop_two", 70'(drop_cnt), 70'd2);
    check("ovf_set", 70'(overflow), 70'd1);
    // Full FIFO with pop and push together.
    cycle(1'b0, 1'b1, 5'd7, 32'h7777, 32'h3000, 1'b0, 1'b1);
    check("drop_unchanged", 70'(drop_cnt), 70'd2);
    for (int i = 0; i < DEPTH + 4; i++) idle(1'b1);

    // Dump with x3 written.
    cycle(1'b0, 1'b1, 5'd3, 32'hABCD, 32'h4000, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1);
    run_to_idle();

    // Reset in the middle of a stalled dump at idx 12.
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1);
    for (int k = 0; k < 500 && !(mode == 2 && didx == 12); k++)
      cycle(1'b0, ($urandom_range(3) == 0), 5'($urandom), $urandom, $urandom, 1'b0, ($urandom_range(1) == 1));
    check("reached_idx12", 70'(didx), 70'd12);
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    check("rst_valid", 70'(out_valid), 70'd0);
    check("rst_retire", 70'(retire_cnt), 70'd0);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1, 1'b1);
    run_to_idle();

    // Randomized traffic with stall bursts, dumps and rare resets.
    for (int n = 0; n < 4000; n++) begin
      bit stall_phase;
      stall_phase = ((n / 64) % 3 == 1);
      cycle(($urandom_range(799) == 0),
            ($urandom_range(1) == 1),
            ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom),
            $urandom, $urandom,
            ($urandom_range(40) == 0),
            stall_phase ? ($urandom_range(5) == 0) : ($urandom_range(3) != 0));
    end
    run_to_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
